fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Multi-cycle control sequencer for the 8-bit RISC core. It owns the program counter, drives the combinational instruction memory address, and latches the returned 16-bit word into the instruction register. It steps a FETCH/DECODE/EXECUTE state machine and resolves JMP, JZ and HALT locally. It issues a one-cycle register-write strobe to the ALU/register-file datapath for every other opcode.

Parameters:
PC_WIDTH, 8, program counter and instruction memory address width
INSTR_WIDTH, 16, instruction word width
RESET_PC, 8'h00, PC value after reset and on start
OP_JMP, 4'h8, unconditional jump opcode
OP_JZ, 4'h9, jump-if-zero opcode
OP_HALT, 4'hF, halt opcode

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level; begins or restarts execution from RESET_PC when in IDLE or HALTED
stall  input  1  freezes state, pc, ir and counter; forces reg_we low
instruction  input  16  word from instruction memory at address pc (combinational, same cycle)
zero_flag  input  1  registered ALU zero flag, valid in EXECUTE
pc  output  8  instruction memory address
ir  output  16  latched instruction register
opcode  output  4  ir[15:12], decoded for the datapath
reg_we  output  1  one-cycle datapath write strobe
busy  output  1  high in FETCH/DECODE/EXECUTE
halted  output  1  high in HALTED
retired  output  16  count of completed instructions, saturating at 16'hFFFF

Behaviour:
- Async reset (rst_n=0): state=IDLE, pc=RESET_PC, ir=0, reg_we=0, busy=0, halted=0, retired=0. Reset mid-instruction aborts the instruction with no write strobe.
- States: IDLE, FETCH, DECODE, EXECUTE, HALTED. Each state lasts one cycle unless stall=1.
- IDLE: on start=1, pc<=RESET_PC, retired<=0, go to FETCH.
- FETCH: ir<=instruction. Go to DECODE.
- DECODE: opcode is stable from ir. No side effects. Go to EXECUTE.
- EXECUTE, by ir[15:12]:
  - OP_JMP: pc<=ir[11:4], reg_we=0.
  - OP_JZ: if zero_flag=1, pc<=ir[11:4]; else pc<=pc+1. reg_we=0.
  - OP_HALT: pc unchanged (stays on the HALT word), go to HALTED, retired+1.
  - Any other opcode: reg_we=1 for exactly this cycle, pc<=pc+1.
  - All non-HALT opcodes: retired+1, then go to FETCH.
- Latency: 3 cycles per instruction. The first fetch is sampled on the first FETCH cycle, i.e. 1 cycle after start is accepted in IDLE.
- PC arithmetic is modulo 2^PC_WIDTH: 8'hFF+1 = 8'h00. A jump target of 8'hFF is legal.
- The retired counter saturates at 16'hFFFF and does not wrap.
- stall=1 in any state: hold state, pc, ir and retired; reg_we=0.
- stall releasing in EXECUTE: the instruction executes on the first un-stalled cycle. zero_flag is sampled on that cycle.
- HALTED: halted=1, busy=0. start=1 restarts exactly as from IDLE (pc=RESET_PC, retired=0). Otherwise stay in HALTED.
- start in FETCH/DECODE/EXECUTE is ignored.
- start and stall both high in IDLE/HALTED: stall wins, and the start is taken on the first cycle with stall=0 while start is still high.
- reg_we, busy and halted are registered. reg_we is high only during the EXECUTE cycle, aligned to the state register.

Test Plan:
- Reset, program {C005,C107,0010,F000}, start pulse -> pc sequence 0,1,2,3; reg_we high once per instruction on EXECUTE cycles 3,6,9 after start; halted=1 at pc=3; retired=4.
- Word 8020 at addr 5 -> after EXECUTE pc=8'h02, reg_we=0, next FETCH at address 2.
- JZ 9030 at addr 6 with zero_flag=1 -> pc=8'h03; same with zero_flag=0 -> pc=8'h07; no reg_we in either case.
- Program of non-branch words filling 0..FF, with stall=1 for 5 cycles mid-DECODE at pc=FE -> state, pc and ir frozen; pc wraps FF->00 with no glitch; total 3 cycles per instruction plus 5 stall cycles.
- rst_n deasserted asynchronously mid-EXECUTE of C005 -> reg_we never asserts; all outputs at reset values before the next clock edge.
- In HALTED, start=1 -> pc=00, retired=0, busy=1 next cycle; start asserted during FETCH has no effect.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Control sequencer for the 8-bit RISC core: owns the PC and IR, steps FETCH/DECODE/EXECUTE,
// resolves JMP/JZ/HALT locally and strobes reg_we for every other opcode.
module fetch_sequencer #(
    parameter int unsigned          PC_WIDTH    = 8,
    parameter int unsigned          INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = 8'h00,
    parameter logic [3:0]           OP_JMP      = 4'h8,
    parameter logic [3:0]           OP_JZ       = 4'h9,
    parameter logic [3:0]           OP_HALT     = 4'hF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stall,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   zero_flag,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [INSTR_WIDTH-1:0] ir,
    output logic [3:0]             opcode,
    output logic                   reg_we,
    output logic                   busy,
    output logic                   halted,
    output logic [15:0]            retired
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_HALTED  = 3'd4
    } state_t;

    state_t                   state_r;
    logic [PC_WIDTH-1:0]      pc_r;
    logic [INSTR_WIDTH-1:0]   ir_r;
    logic                     reg_we_r;
    logic                     busy_r;
    logic                     halted_r;
    logic [15:0]              retired_r;
    logic [3:0]               op_s;
    logic                     is_local_s;
    logic [PC_WIDTH-1:0]      target_s;
    logic [PC_WIDTH-1:0]      pc_next_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            sat_inc = value;
        end else begin
            sat_inc = value + 16'd1;
        end
    endfunction

    assign op_s      = ir_r[INSTR_WIDTH-1 -: 4];
    assign target_s  = ir_r[4 +: PC_WIDTH];
    assign pc_next_s = pc_r + {{(PC_WIDTH-1){1'b0}}, 1'b1};

    // Opcodes handled inside the sequencer never produce a datapath write.
    always_comb begin
        is_local_s = 1'b0;
        case (op_s)
            OP_JMP, OP_JZ, OP_HALT: is_local_s = 1'b1;
            default:                is_local_s = 1'b0;
        endcase
    end

    // Sequencer state machine with registered status and strobe outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            pc_r      <= RESET_PC;
            ir_r      <= {INSTR_WIDTH{1'b0}};
            reg_we_r  <= 1'b0;
            busy_r    <= 1'b0;
            halted_r  <= 1'b0;
            retired_r <= 16'd0;
        end else if (stall) begin
            // Everything holds; a pending strobe is masked at the output while stalled.
            state_r <= state_r;
        end else begin
            case (state_r)
                S_IDLE, S_HALTED: begin
                    reg_we_r <= 1'b0;
                    if (start) begin
                        state_r   <= S_FETCH;
                        pc_r      <= RESET_PC;
                        retired_r <= 16'd0;
                        busy_r    <= 1'b1;
                        halted_r  <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                S_FETCH: begin
                    ir_r     <= instruction;
                    reg_we_r <= 1'b0;
                    state_r  <= S_DECODE;
                end
                S_DECODE: begin
                    reg_we_r <= !is_local_s;
                    state_r  <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    reg_we_r  <= 1'b0;
                    retired_r <= sat_inc(retired_r);
                    state_r   <= S_FETCH;
                    case (op_s)
                        OP_JMP:  pc_r <= target_s;
                        OP_JZ:   pc_r <= zero_flag ? target_s : pc_next_s;
                        OP_HALT: begin
                            state_r  <= S_HALTED;
                            busy_r   <= 1'b0;
                            halted_r <= 1'b1;
                        end
                        default: pc_r <= pc_next_s;
                    endcase
                end
                default: begin
                    state_r  <= S_IDLE;
                    reg_we_r <= 1'b0;
                    busy_r   <= 1'b0;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    assign pc      = pc_r;
    assign ir      = ir_r;
    assign opcode  = op_s;
    assign reg_we  = reg_we_r & ~stall;
    assign busy    = busy_r;
    assign halted  = halted_r;
    assign retired = retired_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a per-cycle vector table for the basic program, then
// hand sequences for branches, PC wrap under stall, and asynchronous reset mid-EXECUTE.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        zero_flag = 1'b0;
    logic [15:0] instruction;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [3:0]  opcode;
    logic        reg_we;
    logic        busy;
    logic        halted;
    logic [15:0] retired;

    logic [15:0] mem [256];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    typedef struct {
        logic        start;
        logic        stall;
        logic        zf;
        logic [7:0]  pc;
        logic [15:0] ir;
        logic        we;
        logic        busy;
        logic        halted;
        logic [15:0] ret;
    } vec_t;

    vec_t vecs [20];

    assign instruction = mem[pc];

    fetch_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stall       (stall),
        .instruction (instruction),
        .zero_flag   (zero_flag),
        .pc          (pc),
        .ir          (ir),
        .opcode      (opcode),
        .reg_we      (reg_we),
        .busy        (busy),
        .halted      (halted),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input logic st, input logic sl);
        @(negedge clk);
        start = st;
        stall = sl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // From FETCH: run one instruction, check the EXECUTE strobe and the resulting PC.
    task automatic exec_one(input logic [7:0] exp_pc, input logic exp_we);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("exec_we", {31'd0, reg_we}, {31'd0, exp_we});
        step(1'b0, 1'b0);
        check("next_pc", {24'd0, pc}, {24'd0, exp_pc});
    endtask

    function automatic vec_t mk(input logic st, input logic sl, input logic [7:0] p,
                                input logic [15:0] i, input logic w, input logic b,
                                input logic h, input logic [15:0] r);
        vec_t v;
        v.start = st; v.stall = sl; v.zf = 1'b0; v.pc = p; v.ir = i;
        v.we = w; v.busy = b; v.halted = h; v.ret = r;
        return v;
    endfunction

    initial begin
        int c0;
        vecs[0]  = mk(1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 16'd0);
        vecs[1]  = mk(1'b0, 1'b0, 8'h00, 16'hC005, 1'b0, 1'b1, 1'b0, 16'd0);
        vecs[2]  = mk(1'b0, 1'b0, 8'h00, 16'hC005, 1'b1, 1'b1, 1'b0, 16'd0);
        vecs[3]  = mk(1'b0, 1'b0, 8'h01, 16'hC005, 1'b0, 1'b1, 1'b0, 16'd1);
        vecs[4]  = mk(1'b1, 1'b0, 8'h01, 16'hC107, 1'b0, 1'b1, 1'b0, 16'd1);
        vecs[5]  = mk(1'b0, 1'b0, 8'h01, 16'hC107, 1'b1, 1'b1, 1'b0, 16'd1);
        vecs[6]  = mk(1'b0, 1'b0, 8'h02, 16'hC107, 1'b0, 1'b1, 1'b0, 16'd2);
        vecs[7]  = mk(1'b0, 1'b0, 8'h02, 16'h0010, 1'b0, 1'b1, 1'b0, 16'd2);
        vecs[8]  = mk(1'b0, 1'b0, 8'h02, 16'h0010, 1'b1, 1'b1, 1'b0, 16'd2);
        vecs[9]  = mk(1'b0, 1'b0, 8'h03, 16'h0010, 1'b0, 1'b1, 1'b0, 16'd3);
        vecs[10] = mk(1'b0, 1'b0, 8'h03, 16'hF000, 1'b0, 1'b1, 1'b0, 16'd3);
        vecs[11] = mk(1'b0, 1'b0, 8'h03, 16'hF000, 1'b0, 1'b1, 1'b0, 16'd3);
        vecs[12] = mk(1'b0, 1'b0, 8'h03, 16'hF000, 1'b0, 1'b0, 1'b1, 16'd4);
        vecs[13] = mk(1'b0, 1'b0, 8'h03, 16'hF000, 1'b0, 1'b0, 1'b1, 16'd4);
        vecs[14] = mk(1'b1, 1'b1, 8'h03, 16'hF000, 1'b0, 1'b0, 1'b1, 16'd4);
        vecs[15] = mk(1'b1, 1'b0, 8'h00, 16'hF000, 1'b0, 1'b1, 1'b0, 16'd0);
        vecs[16] = mk(1'b0, 1'b0, 8'h00, 16'hC005, 1'b0, 1'b1, 1'b0, 16'd0);
        vecs[17] = mk(1'b0, 1'b0, 8'h00, 16'hC005, 1'b1, 1'b1, 1'b0, 16'd0);
        vecs[18] = mk(1'b0, 1'b1, 8'h00, 16'hC005, 1'b0, 1'b1, 1'b0, 16'd0);
        vecs[19] = mk(1'b0, 1'b0, 8'h01, 16'hC005, 1'b0, 1'b1, 1'b0, 16'd1);

        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
        mem[0] = 16'hC005; mem[1] = 16'hC107; mem[2] = 16'h0010; mem[3] = 16'hF000;

        // Reset values
        #2;
        check("rst_pc", {24'd0, pc}, 32'h0);
        check("rst_ir", {16'd0, ir}, 32'h0);
        check("rst_opcode", {28'd0, opcode}, 32'h0);
        check("rst_we", {31'd0, reg_we}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_halted", {31'd0, halted}, 32'h0);
        check("rst_retired", {16'd0, retired}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0);
        check("idle_busy", {31'd0, busy}, 32'h0);

        // Basic program, halt, stalled restart, restart, stall in EXECUTE
        for (int i = 0; i < 20; i++) begin
            zero_flag = vecs[i].zf;
            step(vecs[i].start, vecs[i].stall);
            check($sformatf("v%0d_pc", i), {24'd0, pc}, {24'd0, vecs[i].pc});
            check($sformatf("v%0d_ir", i), {16'd0, ir}, {16'd0, vecs[i].ir});
            check($sformatf("v%0d_we", i), {31'd0, reg_we}, {31'd0, vecs[i].we});
            check($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
            check($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].halted});
            check($sformatf("v%0d_retired", i), {16'd0, retired}, {16'd0, vecs[i].ret});
        end

        // Branches: 0:JMP 5, 5:JMP 2, 2:JMP 6, 6:JZ 3, 3/7:HALT
        do_reset();
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
        mem[0] = 16'h8050; mem[5] = 16'h8020; mem[2] = 16'h8060; mem[6] = 16'h9030;
        zero_flag = 1'b1;
        step(1'b1, 1'b0);
        exec_one(8'h05, 1'b0);
        exec_one(8'h02, 1'b0);
        exec_one(8'h06, 1'b0);
        exec_one(8'h03, 1'b0);
        exec_one(8'h03, 1'b0);
        check("jz1_halted", {31'd0, halted}, 32'h1);
        check("jz1_retired", {16'd0, retired}, 32'd5);
        zero_flag = 1'b0;
        step(1'b1, 1'b0);
        exec_one(8'h05, 1'b0);
        exec_one(8'h02, 1'b0);
        exec_one(8'h06, 1'b0);
        exec_one(8'h07, 1'b0);
        exec_one(8'h07, 1'b0);
        check("jz0_halted", {31'd0, halted}, 32'h1);

        // PC wrap with a 5-cycle stall in DECODE at FE
        do_reset();
        for (int i = 0; i < 256; i++) mem[i] = {4'h1, i[7:0], 4'h0};
        step(1'b1, 1'b0);
        c0 = cyc;
        for (int i = 0; i < 254; i++) exec_one(8'(i + 1), 1'b1);
        step(1'b0, 1'b0);
        check("wrap_dec_ir", {16'd0, ir}, 32'h1FE0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1);
            check("stall_pc", {24'd0, pc}, 32'hFE);
            check("stall_ir", {16'd0, ir}, 32'h1FE0);
            check("stall_we", {31'd0, reg_we}, 32'h0);
        end
        step(1'b0, 1'b0);
        check("wrap_exec_we", {31'd0, reg_we}, 32'h1);
        step(1'b0, 1'b0);
        check("wrap_pc_ff", {24'd0, pc}, 32'hFF);
        exec_one(8'h00, 1'b1);
        check("wrap_retired", {16'd0, retired}, 32'd256);
        check("wrap_cycles", cyc - c0, 32'd773);

        // Async reset in the middle of EXECUTE of C005
        do_reset();
        mem[0] = 16'hC005;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("pre_rst_we", {31'd0, reg_we}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_we", {31'd0, reg_we}, 32'h0);
        check("arst_pc", {24'd0, pc}, 32'h0);
        check("arst_ir", {16'd0, ir}, 32'h0);
        check("arst_busy", {31'd0, busy}, 32'h0);
        check("arst_retired", {16'd0, retired}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            check("post_rst_we", {31'd0, reg_we}, 32'h0);
            check("post_rst_busy", {31'd0, busy}, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
